byte_unstriping_rx_param: RTL and testbench

Parametrised receive-side byte un-striper: merges LANES parallel lanes of WIDTH-bit words back into one serial word stream in round-robin lane order. Each lane has a DEPTH-entry FIFO that absorbs inter-lane skew. The lane count is programmable at reset. Sits after the per-lane receive logic and feeds the single-stream datapath; it replaces the fixed 4-lane, 8-bit un-striper.

---
 rtl/byte_unstriping_rx_param_if.sv | 24 ++
 rtl/byte_unstriping_rx_param.sv | 134 +++++++++++++
 tb/tb_byte_unstriping_rx_param.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_unstriping_rx_param_if.sv
// Lane-side input bus and merged-stream output bus of the receive un-striper.
interface byte_unstriping_rx_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
);
  logic [LANES-1:0]       valid_in;
  logic [LANES*WIDTH-1:0] data_in;
  logic [WIDTH-1:0]       data_out;
  logic                   valid_out;

  modport master (
    output valid_in,
    output data_in,
    input  data_out,
    input  valid_out
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output data_out,
    output valid_out
  );
endinterface

// File: rtl/byte_unstriping_rx_param.sv
// Receive byte un-striper: per-lane skew FIFOs merged round-robin into one word stream.
module byte_unstriping_rx_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LCW   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LCW-1:0]             lane_cnt,
  byte_unstriping_rx_param_if.slave  lanes_if,
  output logic [LANES-1:0]           overflow,
  output logic                       idle
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned RRW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WIDTH-1:0] mem_q  [LANES][DEPTH];
  logic [WIDTH-1:0] mem_d  [LANES][DEPTH];
  logic [PW-1:0]    wptr_q [LANES];
  logic [PW-1:0]    wptr_d [LANES];
  logic [PW-1:0]    rptr_q [LANES];
  logic [PW-1:0]    rptr_d [LANES];
  logic [CW-1:0]    cnt_q  [LANES];
  logic [CW-1:0]    cnt_d  [LANES];

  logic [LANES-1:0] ovf_q, ovf_d;
  logic [RRW-1:0]   rr_q, rr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vout_q, vout_d;
  logic [LCW-1:0]   act_q, act_load;

  logic             pop_any;
  logic [LANES-1:0] popping, push_req, full, accept;

  // Out-of-range lane counts (0 or above LANES) fall back to all physical lanes.
  always_comb begin
    act_load = lane_cnt;
    if (lane_cnt == '0 || lane_cnt > LCW'(LANES)) begin
      act_load = LCW'(LANES);
    end
  end

  // Next-state: pop the round-robin lane if it has data, then push/overflow per lane.
  always_comb begin
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    rr_d     = rr_q;
    dout_d   = dout_q;
    vout_d   = 1'b0;
    popping  = '0;
    push_req = '0;
    full     = '0;
    accept   = '0;

    // rr never skips an empty lane, which is what preserves striping order under skew.
    pop_any = (cnt_q[rr_q] != '0);
    if (pop_any) begin
      dout_d       = mem_q[rr_q][rptr_q[rr_q]];
      vout_d       = 1'b1;
      rptr_d[rr_q] = rptr_q[rr_q] + 1'b1;
      rr_d         = (int'(rr_q) >= int'(act_q) - 1) ? '0 : rr_q + 1'b1;
    end

    for (int i = 0; i < int'(LANES); i++) begin
      popping[i]  = pop_any && (int'(rr_q) == i);
      push_req[i] = lanes_if.valid_in[i] && (i < int'(act_q));
      full[i]     = (cnt_q[i] == CW'(DEPTH));
      // A full FIFO still accepts when its head leaves on the same edge.
      accept[i]   = push_req[i] && (!full[i] || popping[i]);
      if (accept[i]) begin
        mem_d[i][wptr_q[i]] = lanes_if.data_in[i*WIDTH +: WIDTH];
        wptr_d[i]           = wptr_q[i] + 1'b1;
      end
      if (push_req[i] && !accept[i]) begin
        ovf_d[i] = 1'b1;
      end
      if (accept[i] && !popping[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!accept[i] && popping[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Control state with synchronous active-low reset; lane count latched only in reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(LANES); i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ovf_q  <= '0;
      rr_q   <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      act_q  <= act_load;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
    end
  end

  // Storage is not reset; emptiness is tracked by the counters alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Idle when every FIFO occupancy counter reads zero.
  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < int'(LANES); i++) begin
      if (cnt_q[i] != '0) begin
        idle = 1'b0;
      end
    end
  end

  assign lanes_if.data_out  = dout_q;
  assign lanes_if.valid_out = vout_q;
  assign overflow           = ovf_q;

endmodule

// File: tb/tb_byte_unstriping_rx_param.sv
// Directed self-checking bench for the 4-lane, 8-bit, depth-4 un-striper.
module tb_byte_unstriping_rx_param;

  logic       clk;
  logic       reset;
  logic [2:0] lane_cnt;
  logic [3:0] overflow;
  logic       idle;
  int         checks;
  int         failures;

  byte_unstriping_rx_param_if #(.WIDTH(8), .LANES(4)) bus ();

  byte_unstriping_rx_param #(
    .WIDTH(8),
    .LANES(4),
    .DEPTH(4),
    .LCW  (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .lane_cnt(lane_cnt),
    .lanes_if(bus),
    .overflow(overflow),
    .idle    (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One reset edge; lane_cnt is then moved to a different value to prove it is ignored.
  task automatic do_reset(input logic [2:0] cnt);
    reset        = 1'b0;
    lane_cnt     = cnt;
    bus.valid_in = '0;
    bus.data_in  = '0;
    tick();
    reset    = 1'b1;
    lane_cnt = 3'd1;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    lane_cnt     = 3'd4;
    bus.valid_in = 4'b1111;
    bus.data_in  = 32'hAABBCCDD;
    tick();
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out);
    end
    checks++;
    if (bus.data_out !== 8'h00) begin
      failures++; $display("FAIL reset_data: got %h expected 00", bus.data_out);
    end
    checks++;
    if (idle !== 1'b1) begin
      failures++; $display("FAIL reset_idle: got %b expected 1", idle);
    end
    checks++;
    if (overflow !== 4'b0000) begin
      failures++; $display("FAIL reset_overflow: got %b expected 0000", overflow);
    end
    reset = 1'b1;
  endtask

  task automatic test_aligned();
    logic [7:0] exp;
    do_reset(3'd0);
    bus.valid_in = 4'b1111;
    bus.data_in  = {8'h04, 8'h03, 8'h02, 8'h01};
    tick();
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++; $display("FAIL aligned_no_bypass: got %b expected 0", bus.valid_out);
    end
    bus.data_in = {8'h08, 8'h07, 8'h06, 8'h05};
    for (int j = 0; j < 8; j++) begin
      tick();
      bus.valid_in = '0;
      exp = 8'(j + 1);
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp) begin
        failures++;
        $display("FAIL aligned_word%0d: got v=%b d=%h expected v=1 d=%h",
                 j, bus.valid_out, bus.data_out, exp);
      end
    end
    tick();
    checks++;
    if (bus.valid_out !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL aligned_drain: got v=%b idle=%b expected v=0 idle=1", bus.valid_out, idle);
    end
  endtask

  task automatic test_skew();
    logic [3:0] vin   [6] = '{4'b1011, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic [31:0] din  [6] = '{32'h04000201, 32'h0, 32'h0, 32'h00030000, 32'h0, 32'h0};
    logic        ev   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  ed   [6] = '{8'h00, 8'h01, 8'h02, 8'h02, 8'h03, 8'h04};
    do_reset(3'd7);
    for (int j = 0; j < 6; j++) begin
      bus.valid_in = vin[j];
      bus.data_in  = din[j];
      tick();
      checks++;
      if (bus.valid_out !== ev[j] || bus.data_out !== ed[j]) begin
        failures++;
        $display("FAIL skew_edge%0d: got v=%b d=%h expected v=%b d=%h",
                 j, bus.valid_out, bus.data_out, ev[j], ed[j]);
      end
    end
    bus.valid_in = '0;
    tick();
    checks++;
    if (bus.valid_out !== 1'b0 || overflow !== 4'b0000) begin
      failures++;
      $display("FAIL skew_end: got v=%b ovf=%b expected v=0 ovf=0000", bus.valid_out, overflow);
    end
  endtask

  task automatic test_reduced_lanes();
    logic [3:0] vin  [7] = '{4'b1111, 4'b1011, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic [31:0] din [7] = '{32'hEEEE0B0A, 32'hEEEE0D0C, 32'h00EE0000, 32'hEE000000,
                             32'h0, 32'h0, 32'h0};
    logic        ev  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  ed  [7] = '{8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0D, 8'h0D};
    do_reset(3'd2);
    lane_cnt = 3'd4;
    for (int j = 0; j < 7; j++) begin
      bus.valid_in = vin[j];
      bus.data_in  = din[j];
      tick();
      checks++;
      if (bus.valid_out !== ev[j] || bus.data_out !== ed[j]) begin
        failures++;
        $display("FAIL reduced_edge%0d: got v=%b d=%h expected v=%b d=%h",
                 j, bus.valid_out, bus.data_out, ev[j], ed[j]);
      end
    end
    bus.valid_in = '0;
    checks++;
    if (idle !== 1'b1 || overflow !== 4'b0000) begin
      failures++;
      $display("FAIL reduced_idle: got idle=%b ovf=%b expected idle=1 ovf=0000", idle, overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset(3'd4);
    lane_cnt = 3'd4;
    for (int j = 0; j < 5; j++) begin
      bus.valid_in = 4'b0010;
      bus.data_in  = {16'h0, 8'(8'h11 + j), 8'h00};
      tick();
      if (j == 3) begin
        checks++;
        if (overflow !== 4'b0000) begin
          failures++; $display("FAIL ovf_at_full: got %b expected 0000", overflow);
        end
      end
    end
    checks++;
    if (overflow !== 4'b0010 || bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL ovf_fifth: got ovf=%b v=%b expected ovf=0010 v=0", overflow, bus.valid_out);
    end
    bus.valid_in = 4'b0001;
    bus.data_in  = 32'h00000010;
    tick();
    bus.valid_in = '0;
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h10) begin
      failures++;
      $display("FAIL ovf_out10: got v=%b d=%h expected v=1 d=10", bus.valid_out, bus.data_out);
    end
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h11) begin
      failures++;
      $display("FAIL ovf_out11: got v=%b d=%h expected v=1 d=11", bus.valid_out, bus.data_out);
    end
    tick();
    checks++;
    if (bus.valid_out !== 1'b0 || idle !== 1'b0 || overflow !== 4'b0010) begin
      failures++;
      $display("FAIL ovf_stall: got v=%b idle=%b ovf=%b expected v=0 idle=0 ovf=0010",
               bus.valid_out, idle, overflow);
    end
  endtask

  task automatic test_full_pop();
    logic [1:0] vin [16] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b11, 2'b10,
                             2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [7:0] d0  [16] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h00, 8'h25, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] d1  [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h31, 8'h32,
                             8'h33, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       ev  [16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed  [16] = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h30, 8'h21, 8'h31,
                             8'h22, 8'h32, 8'h23, 8'h33, 8'h24, 8'h34, 8'h25, 8'h25};
    do_reset(3'd2);
    for (int j = 0; j < 16; j++) begin
      bus.valid_in = {2'b00, vin[j]};
      bus.data_in  = {16'h0, d1[j], d0[j]};
      tick();
      checks++;
      if (bus.valid_out !== ev[j] || bus.data_out !== ed[j]) begin
        failures++;
        $display("FAIL fullpop_edge%0d: got v=%b d=%h expected v=%b d=%h",
                 j + 1, bus.valid_out, bus.data_out, ev[j], ed[j]);
      end
    end
    bus.valid_in = '0;
    checks++;
    if (overflow !== 4'b0000 || idle !== 1'b1) begin
      failures++;
      $display("FAIL fullpop_end: got ovf=%b idle=%b expected ovf=0000 idle=1", overflow, idle);
    end
  endtask

  // Runs straight after test_overflow: lane 1 still holds three words and overflow is set.
  task automatic test_reset_mid();
    logic [7:0] exp;
    checks++;
    if (idle !== 1'b0) begin
      failures++; $display("FAIL mid_precondition: got idle=%b expected 0", idle);
    end
    reset        = 1'b0;
    lane_cnt     = 3'd4;
    bus.valid_in = '0;
    tick();
    reset = 1'b1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00 || idle !== 1'b1 ||
        overflow !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset: got v=%b d=%h idle=%b ovf=%b expected v=0 d=00 idle=1 ovf=0000",
               bus.valid_out, bus.data_out, idle, overflow);
    end
    bus.valid_in = 4'b1111;
    bus.data_in  = {8'h04, 8'h03, 8'h02, 8'h01};
    tick();
    bus.valid_in = '0;
    for (int j = 0; j < 4; j++) begin
      tick();
      exp = 8'(j + 1);
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp) begin
        failures++;
        $display("FAIL mid_burst%0d: got v=%b d=%h expected v=1 d=%h",
                 j, bus.valid_out, bus.data_out, exp);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    lane_cnt     = 3'd4;
    bus.valid_in = '0;
    bus.data_in  = '0;
    test_reset();
    test_aligned();
    test_skew();
    test_reduced_lanes();
    test_full_pop();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
